// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, parity/framing/overrun reporting and a receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry circular buffer; otherwise a single holding register.
module uart_rx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 20,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_i,
  input  logic                          reset_ready,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          data,
  output logic                          ready,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY_MODE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]        clk_cnt, clk_cnt_next;
  logic [3:0]           bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_bad, par_bad_next;
  logic                 push_frame, frame_fail;
  logic                 pop, push, full, overrun_set;

  // Synchroniser plus one extra stage so IDLE can see a clean falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bad   <= 1'b0;
    end else begin
      state     <= state_next;
      clk_cnt   <= clk_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
      par_bad   <= par_bad_next;
    end
  end

  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt + CW'(1);
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    par_bad_next = par_bad;
    push_frame   = 1'b0;
    frame_fail   = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        if (rx_prev && !rx_sync) state_next = START;
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_next = '0;
          state_next   = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          shift_next   = {rx_sync, shift_reg[DATA_BITS-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_next = '0;
            par_bad_next = 1'b0;
            state_next   = (PARITY_MODE == 0) ? STOP : PARITY;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          par_bad_next = ((^shift_reg) ^ rx_sync) != ODD_PAR;
          state_next   = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          if (!rx_sync) begin
            frame_fail = 1'b1;
            state_next = IDLE;
          end else if (bit_cnt == STOP_LAST) begin
            push_frame = 1'b1;
            state_next = IDLE;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pop         = reset_ready & ready;
  assign push        = push_frame & (~full | pop);
  assign overrun_set = push_frame & full & ~pop;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        count;

  assign full  = (count == LW'(FIFO_DEPTH));
  assign ready = (count != '0);
  assign data  = ready ? mem[rd_ptr] : '0;
  assign level = count;

  // Storage has no reset; data is masked to zero while the buffer is empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end
`else
  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;

  assign full  = hold_valid;
  assign ready = hold_valid;
  assign data  = hold_valid ? hold_data : '0;
  assign level = LW'(hold_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= shift_reg;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // A new overrun wins over a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= push_frame & par_bad;
      frame_err  <= frame_fail;
      if (overrun_set)  overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo: 8 data bits, even parity, 1 stop bit, 20 clks per bit.
// Follows UART_RX_FIFO_EN the same way the design does.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_i;
  logic       reset_ready;
  logic       clr_err;
  logic [7:0] data;
  logic       ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic [2:0] level;

  int  tests_run = 0;
  int  tests_failed = 0;
  int  perr_cnt = 0;
  int  ferr_cnt = 0;
  int  p0, f0;
  logic ready_q = 1'b0;
  time start_t = 0;
  time rise_t = 0;

  uart_rx_fifo #(
    .DATA_BITS(8), .CLKS_PER_BIT(20), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .rx_i(rx_i), .reset_ready(reset_ready), .clr_err(clr_err),
    .data(data), .ready(ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .level(level)
  );

  always #10 clk = ~clk;

  // Pulse counters and ready rising-edge timestamp, sampled mid-cycle
  always @(negedge clk) begin
    if (parity_err) perr_cnt++;
    if (frame_err)  ferr_cnt++;
    if (ready && !ready_q) rise_t = $time;
    ready_q = ready;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one full frame starting on a falling clock edge: start, 8 data LSB first, parity, stop
  task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    @(negedge clk);
    start_t = $time;
    for (int i = 0; i < 11; i++) begin
      rx_i = bits[i];
      repeat (20) @(negedge clk);
    end
    rx_i = 1'b1;
  endtask

  task automatic popWord();
    @(negedge clk);
    reset_ready = 1'b1;
    @(negedge clk);
    reset_ready = 1'b0;
  endtask

  task automatic snap();
    p0 = perr_cnt;
    f0 = ferr_cnt;
  endtask

  initial begin
    reset = 1'b1;
    rx_i = 1'b1;
    reset_ready = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_data", 32'(data), 32'h0);
    checkOutput("rst_ready", 32'(ready), 32'h0);
    checkOutput("rst_level", 32'(level), 32'h0);
    checkOutput("rst_errs", 32'({parity_err, frame_err, overrun}), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: good frame, exact latency from start edge to ready, then pop
    snap();
    applyStimulus(8'h1D, 1'b0, 1'b1);
    checkOutput("t1_latency", 32'((rise_t - start_t) / 20), 32'd213);
    checkOutput("t1_ready", 32'(ready), 32'h1);
    checkOutput("t1_data", 32'(data), 32'h1D);
    checkOutput("t1_level", 32'(level), 32'h1);
    checkOutput("t1_perr", 32'(perr_cnt - p0), 32'h0);
    checkOutput("t1_ferr", 32'(ferr_cnt - f0), 32'h0);
    popWord();
    checkOutput("t1_pop_ready", 32'(ready), 32'h0);
    checkOutput("t1_pop_level", 32'(level), 32'h0);
    checkOutput("t1_pop_data", 32'(data), 32'h0);
    popWord();
    checkOutput("t1_empty_pop", 32'(level), 32'h0);

    // 2: bad parity is flagged but the word is still stored
    snap();
    applyStimulus(8'h1D, 1'b1, 1'b1);
    checkOutput("t2_perr", 32'(perr_cnt - p0), 32'h1);
    checkOutput("t2_data", 32'(data), 32'h1D);
    checkOutput("t2_ready", 32'(ready), 32'h1);
    popWord();

    // 3: framing error discards the word; next frame received normally
    snap();
    applyStimulus(8'h1D, 1'b0, 1'b0);
    checkOutput("t3_ferr", 32'(ferr_cnt - f0), 32'h1);
    checkOutput("t3_ready", 32'(ready), 32'h0);
    checkOutput("t3_level", 32'(level), 32'h0);
    applyStimulus(8'hA5, ^8'hA5, 1'b1);
    checkOutput("t3_next_data", 32'(data), 32'hA5);
    popWord();

    // 4: short glitch is rejected silently
    snap();
    @(negedge clk);
    rx_i = 1'b0;
    repeat (5) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("t4_errs", 32'((perr_cnt - p0) + (ferr_cnt - f0)), 32'h0);
    checkOutput("t4_ready", 32'(ready), 32'h0);
    applyStimulus(8'h3C, ^8'h3C, 1'b1);
    checkOutput("t4_next_data", 32'(data), 32'h3C);
    popWord();

    // 5: back-to-back frames without pops fill the buffer and overrun
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), ^(8'(i)), 1'b1);
    checkOutput("t5_level", 32'(level), 32'h4);
    checkOutput("t5_overrun", 32'(overrun), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("t5_pop_data", 32'(data), 32'(i));
      popWord();
    end
    checkOutput("t5_drained", 32'(level), 32'h0);
`else
    for (int i = 1; i <= 2; i++) applyStimulus(8'(i), ^(8'(i)), 1'b1);
    checkOutput("t5_overrun", 32'(overrun), 32'h1);
    checkOutput("t5_data", 32'(data), 32'h01);
    checkOutput("t5_level", 32'(level), 32'h1);
    popWord();
    checkOutput("t5_drained", 32'(ready), 32'h0);
`endif
    checkOutput("t5_sticky", 32'(overrun), 32'h1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checkOutput("t5_clr", 32'(overrun), 32'h0);

    // 6: reset in the middle of a frame, with a word held and overrun set
    applyStimulus(8'h77, ^8'h77, 1'b1);
    applyStimulus(8'h66, ^8'h66, 1'b1);
`ifdef UART_RX_FIFO_EN
    for (int i = 0; i < 3; i++) applyStimulus(8'h55, ^8'h55, 1'b1);
`endif
    checkOutput("t6_pre_overrun", 32'(overrun), 32'h1);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (20) @(negedge clk);
    rx_i = 1'b1;
    repeat (60) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t6_data", 32'(data), 32'h0);
    checkOutput("t6_ready", 32'(ready), 32'h0);
    checkOutput("t6_level", 32'(level), 32'h0);
    checkOutput("t6_errs", 32'({parity_err, frame_err, overrun}), 32'h0);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("t6_abandoned", 32'(ready), 32'h0);
    applyStimulus(8'h5A, ^8'h5A, 1'b1);
    checkOutput("t6_next_data", 32'(data), 32'h5A);
    checkOutput("t6_next_level", 32'(level), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
